// File: rtl/sha_add_sched_if.sv
// Request/result bundle between the SHA-256 datapath requesters and the shared adder.
// The message schedule (A) and the compression rounds (B) each present a level request.
interface sha_add_sched_if #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 5,
    parameter int CW    = 3
);
    logic                  i_req_a;
    logic [CW-1:0]         i_cnt_a;
    logic [NOPS*WIDTH-1:0] i_ops_a;
    logic                  i_req_b;
    logic [CW-1:0]         i_cnt_b;
    logic [NOPS*WIDTH-1:0] i_ops_b;
    logic                  o_done_a;
    logic                  o_done_b;
    logic [WIDTH-1:0]      o_summ;
    logic                  o_carry;
    logic                  o_busy;

    modport master (
        output i_req_a, i_cnt_a, i_ops_a,
        output i_req_b, i_cnt_b, i_ops_b,
        input  o_done_a, o_done_b, o_summ, o_carry, o_busy
    );

    modport slave (
        input  i_req_a, i_cnt_a, i_ops_a,
        input  i_req_b, i_cnt_b, i_ops_b,
        output o_done_a, o_done_b, o_summ, o_carry, o_busy
    );
endinterface

// File: rtl/sha_add_sched.sv
// Shared multi-operand adder for the SHA-256 core: round-robin between the
// message schedule (A) and compression (B), one operand accumulated per cycle.
module adder_32b_param #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] full;
    assign full   = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = full[WIDTH-1:0];
    assign o_cout = full[WIDTH];
endmodule

module sha_add_sched #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 5,
    parameter int CW    = 3
) (
    input logic            i_clk,
    input logic            i_rst,
    sha_add_sched_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    n_q, n_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             cany_q, cany_d;
    logic [WIDTH-1:0] summ_q, summ_d;
    logic             carry_q, carry_d;
    logic             done_a_q, done_a_d;
    logic             done_b_q, done_b_d;
    logic             busy_q, busy_d;

    logic                  gnt_b;
    logic [CW-1:0]         cnt_g;
    logic [CW-1:0]         n_g;
    logic [WIDTH-1:0]      op0_g;
    logic [NOPS*WIDTH-1:0] ops_sel;
    logic [WIDTH-1:0]      op_cur;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;

    adder_32b_param #(.WIDTH(WIDTH)) u_add (
        .i_a    (acc_q),
        .i_b    (op_cur),
        .i_cin  (1'b0),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    // Operands are read live from the granted requester, never captured.
    always_comb begin
        ops_sel = sel_q ? bus.i_ops_b : bus.i_ops_a;
        op_cur  = '0;
        for (int k = 0; k < NOPS; k++) begin
            if (idx_q == CW'(k)) op_cur = ops_sel[k*WIDTH +: WIDTH];
        end
    end

    // last_q set means B was served last, so A wins a tie.
    always_comb begin
        gnt_b = bus.i_req_b & (~bus.i_req_a | ~last_q);
        cnt_g = gnt_b ? bus.i_cnt_b : bus.i_cnt_a;
        n_g   = (cnt_g > CW'(NOPS)) ? CW'(NOPS) : cnt_g;
        op0_g = gnt_b ? bus.i_ops_b[WIDTH-1:0] : bus.i_ops_a[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        n_d      = n_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cany_d   = cany_q;
        summ_d   = summ_q;
        carry_d  = carry_q;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        busy_d   = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_req_a || bus.i_req_b) begin
                    sel_d  = gnt_b;
                    n_d    = n_g;
                    acc_d  = (n_g == '0) ? '0 : op0_g;
                    idx_d  = CW'(1);
                    cany_d = 1'b0;
                    busy_d = 1'b1;
                    if (n_g <= CW'(1)) begin
                        state_d  = S_DONE;
                        summ_d   = acc_d;
                        carry_d  = 1'b0;
                        done_a_d = ~gnt_b;
                        done_b_d = gnt_b;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                acc_d  = add_sum;
                cany_d = cany_q | add_cout;
                idx_d  = idx_q + CW'(1);
                if (idx_q == n_q - CW'(1)) begin
                    state_d  = S_DONE;
                    summ_d   = add_sum;
                    carry_d  = cany_d;
                    done_a_d = ~sel_q;
                    done_b_d = sel_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                last_d  = sel_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            cany_q   <= 1'b0;
            summ_q   <= '0;
            carry_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cany_q   <= cany_d;
            summ_q   <= summ_d;
            carry_q  <= carry_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_done_a = done_a_q;
    assign bus.o_done_b = done_b_q;
    assign bus.o_summ   = summ_q;
    assign bus.o_carry  = carry_q;
    assign bus.o_busy   = busy_q;
endmodule

// File: tb/tb_sha_add_sched.sv
// Randomised and directed checks of sha_add_sched against a transaction-level
// model: sums in 64-bit arithmetic, grant/done timing from operand counts.
module tb_sha_add_sched;
    localparam int WIDTH = 32;
    localparam int NOPS  = 5;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_add_sched_if #(.WIDTH(WIDTH), .NOPS(NOPS), .CW(CW)) bus ();

    sha_add_sched #(.WIDTH(WIDTH), .NOPS(NOPS), .CW(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    // model state
    int          cyc      = 0;
    int          free_at  = 0;
    int          done_at  = -1;
    int          busy_end = -1;
    bit          exp_b    = 1'b0;
    logic [31:0] exp_sum  = '0;
    bit          exp_c    = 1'b0;
    bit          last_b   = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [159:0] pack5(input logic [31:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    // Plain 64-bit sum of the first min(cnt,NOPS) operands.
    function automatic logic [63:0] ref_sum(input logic [CW-1:0] cnt,
                                            input logic [159:0] ops);
        int n;
        logic [63:0] s;
        n = (int'(cnt) > NOPS) ? NOPS : int'(cnt);
        s = '0;
        for (int k = 0; k < n; k++) s = s + {32'd0, ops[k*32 +: 32]};
        return s;
    endfunction

    task automatic model_step();
        bit w;
        int n, m;
        logic [63:0] s;
        if (rst) begin
            free_at  = cyc + 1;
            done_at  = -1;
            busy_end = -1;
            last_b   = 1'b1;
        end else if (cyc >= free_at && (bus.i_req_a || bus.i_req_b)) begin
            w = bus.i_req_b && (!bus.i_req_a || !last_b);
            n = w ? int'(bus.i_cnt_b) : int'(bus.i_cnt_a);
            if (n > NOPS) n = NOPS;
            m = (n < 1) ? 1 : n;
            s = w ? ref_sum(bus.i_cnt_b, bus.i_ops_b)
                  : ref_sum(bus.i_cnt_a, bus.i_ops_a);
            exp_b    = w;
            exp_sum  = s[31:0];
            exp_c    = (s[63:32] != 0);
            done_at  = cyc + m - 1;
            busy_end = cyc + m;
            free_at  = cyc + m + 1;
            last_b   = w;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_step();
        chk("done_a", bus.o_done_a, (cyc == done_at) && !exp_b);
        chk("done_b", bus.o_done_b, (cyc == done_at) && exp_b);
        chk("busy", bus.o_busy, cyc < busy_end);
        if (cyc == done_at) begin
            chk("summ", bus.o_summ, exp_sum);
            chk("carry", bus.o_carry, exp_c);
        end
        cyc++;
    endtask

    task automatic wait_for(input bit b, output logic [31:0] s,
                            output logic c, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        s   = '0;
        c   = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            lat++;
            if (b ? bus.o_done_b : bus.o_done_a) begin
                got = 1'b1;
                s   = bus.o_summ;
                c   = bus.o_carry;
            end
        end
        if (!got) chk(b ? "timeout_b" : "timeout_a", 0, 1);
    endtask

    task automatic wait_any(output bit who);
        bit got;
        got = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (bus.o_done_a || bus.o_done_b) begin
                got = 1'b1;
                who = bus.o_done_b;
            end
        end
        if (!got) chk("timeout_any", 0, 1);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(3, 0))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'($urandom_range(15, 0));
            default: return $urandom;
        endcase
    endfunction

    task automatic new_a();
        bus.i_req_a = 1'b1;
        bus.i_cnt_a = CW'($urandom_range(7, 0));
        bus.i_ops_a = pack5(rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
    endtask

    task automatic new_b();
        bus.i_req_b = 1'b1;
        bus.i_cnt_b = CW'($urandom_range(7, 0));
        bus.i_ops_b = pack5(rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
    endtask

    logic [31:0] s;
    logic        c;
    int          lat;
    bit          who, prev;
    int          ops_done, guard;
    logic [63:0] ref5;

    initial begin
        bus.i_req_a = 1'b0;
        bus.i_cnt_a = '0;
        bus.i_ops_a = '0;
        bus.i_req_b = 1'b0;
        bus.i_cnt_b = '0;
        bus.i_ops_b = '0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_summ", bus.o_summ, 0);
        chk("rst_carry", bus.o_carry, 0);
        chk("rst_done", {bus.o_done_a, bus.o_done_b}, 0);
        chk("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        tick();

        // A alone, five operands
        bus.i_cnt_a = 3'd5;
        bus.i_ops_a = pack5(1, 2, 3, 4, 5);
        bus.i_req_a = 1'b1;
        wait_for(1'b0, s, c, lat);
        bus.i_req_a = 1'b0;
        chk("t1_sum", s, 15);
        chk("t1_carry", c, 0);
        chk("t1_lat", lat, 5);
        tick();

        // B with wrap-around
        bus.i_cnt_b = 3'd2;
        bus.i_ops_b = pack5(32'hFFFF_FFFF, 2, 9, 9, 9);
        bus.i_req_b = 1'b1;
        wait_for(1'b1, s, c, lat);
        bus.i_req_b = 1'b0;
        chk("t3_sum", s, 1);
        chk("t3_carry", c, 1);
        chk("t3_lat", lat, 2);
        tick();

        // count boundaries: 1, 0, 7
        bus.i_cnt_a = 3'd1;
        bus.i_ops_a = pack5(32'hDEAD_BEEF, 1, 1, 1, 1);
        bus.i_req_a = 1'b1;
        wait_for(1'b0, s, c, lat);
        bus.i_req_a = 1'b0;
        chk("t4_one_sum", s, 32'hDEAD_BEEF);
        chk("t4_one_lat", lat, 1);
        tick();
        bus.i_cnt_a = 3'd0;
        bus.i_ops_a = pack5(32'hFFFF_FFFF, 7, 7, 7, 7);
        bus.i_req_a = 1'b1;
        wait_for(1'b0, s, c, lat);
        bus.i_req_a = 1'b0;
        chk("t4_zero_sum", s, 0);
        chk("t4_zero_carry", c, 0);
        chk("t4_zero_lat", lat, 1);
        tick();
        bus.i_cnt_b = 3'd7;
        bus.i_ops_b = pack5(1, 2, 3, 4, 5);
        bus.i_req_b = 1'b1;
        wait_for(1'b1, s, c, lat);
        bus.i_req_b = 1'b0;
        chk("t4_clamp_sum", s, 15);
        chk("t4_clamp_lat", lat, 5);
        tick();

        // re-reset so the pointer favours A, then raise both together
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_cnt_a = 3'd2;
        bus.i_ops_a = pack5(10, 20, 0, 0, 0);
        bus.i_cnt_b = 3'd3;
        bus.i_ops_b = pack5(1, 1, 1, 0, 0);
        bus.i_req_a = 1'b1;
        bus.i_req_b = 1'b1;
        wait_any(who);
        chk("t2_first", who, 0);
        chk("t2_first_sum", bus.o_summ, 30);
        bus.i_cnt_a = 3'd1;
        bus.i_ops_a = pack5(7, 0, 0, 0, 0);
        wait_any(who);
        chk("t2_second", who, 1);
        chk("t2_second_sum", bus.o_summ, 3);
        new_b();
        wait_any(who);
        chk("t2_third", who, 0);
        chk("t2_third_sum", bus.o_summ, 7);
        prev = who;
        for (int i = 0; i < 100; i++) begin
            if (prev) new_b();
            else new_a();
            wait_any(who);
            chk("t2_rr", who, !prev);
            prev = who;
        end
        if (prev) bus.i_req_b = 1'b0;
        else bus.i_req_a = 1'b0;
        wait_any(who);
        chk("t2_drain", who, !prev);
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
        tick();
        tick();

        // reset in the middle of an accumulation
        bus.i_cnt_a = 3'd5;
        bus.i_ops_a = pack5($urandom, $urandom, $urandom, $urandom, $urandom);
        ref5 = ref_sum(bus.i_cnt_a, bus.i_ops_a);
        bus.i_req_a = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", bus.o_busy, 0);
        chk("t5_nodone", {bus.o_done_a, bus.o_done_b}, 0);
        wait_for(1'b0, s, c, lat);
        bus.i_req_a = 1'b0;
        chk("t5_sum", s, ref5[31:0]);
        chk("t5_carry", c, ref5[63:32] != 0);
        tick();

        // random traffic
        ops_done = 0;
        guard    = 0;
        while (ops_done < 4000 && guard < 60000) begin
            tick();
            guard++;
            if (bus.o_done_a) begin
                ops_done++;
                if ($urandom_range(1, 0) == 1) new_a();
                else bus.i_req_a = 1'b0;
            end else if (!bus.i_req_a && $urandom_range(2, 0) == 0) begin
                new_a();
            end
            if (bus.o_done_b) begin
                ops_done++;
                if ($urandom_range(1, 0) == 1) new_b();
                else bus.i_req_b = 1'b0;
            end else if (!bus.i_req_b && $urandom_range(2, 0) == 0) begin
                new_b();
            end
        end
        chk("rand_ops", ops_done >= 4000, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
